coef_col_streamer: RTL and testbench
====================================

Name: coef_col_streamer

Overview:
- Downstream consumer of the coefficient ROM loader. Captures the 16 packed coefficient words (two 7-bit coefficients per 14-bit word) into a local register buffer.
- Once the loader reports done, serves the 8x4 coefficient matrix one column at a time to the MAC datapath over valid/ready handshakes.
- Sits between the loader and the matrix-vector multiply stage.

Parameters:
- COEF_W, 7, width of one coefficient.
- WORD_W, 14, width of a packed word (2*COEF_W).
- ROWS, 8, coefficients per column.
- COLS, 4, number of columns.
- DEPTH, 16, buffer words (ROWS/2*COLS).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- w_en  in  1  loader write strobe.
- w_addr  in  4  loader word address.
- w_data  in  14  packed word; [13:7] = even row, [6:0] = odd row.
- aload_done  in  1  loader finished; level, sampled each cycle.
- col_req_valid  in  1  column request valid.
- col_req_ready  out  1  column request accepted when high with col_req_valid.
- col_sel  in  2  requested column, 0..3.
- coef_valid  out  1  coefficient beat valid.
- coef_ready  in  1  consumer accepts beat.
- coef_data  out  7  coefficient value, unsigned.
- coef_row  out  3  row index of current beat.
- coef_last  out  1  high on row 7 beat.
- buf_loaded  out  1  buffer holds a complete matrix.

Behaviour:
- Reset (async assert, sync release): state LOAD, all 16 buffer words = 0. Outputs: coef_valid=0, coef_data=0, coef_row=0, coef_last=0, col_req_ready=0, buf_loaded=0.
- Addressing: word address = 4*col + row/2. Even row -> bits [13:7]; odd row -> bits [6:0].
- **LOAD state:**
  - w_en=1 writes w_data to buf[w_addr] at the clock edge.
  - aload_done=1 -> IDLE next cycle. A write in the same cycle as aload_done is still applied.
  - col_req_ready=0; requests are ignored.
- **IDLE state:**
  - buf_loaded=1, col_req_ready=1.
  - col_req_valid=1 latches col_sel, sets row counter to 0, moves to STREAM.
  - w_en is ignored. Buffer is frozen until the next reset.
- **STREAM state:**
  - Outputs are registered. First beat appears the cycle after request acceptance (latency 1).
  - coef_valid=1. coef_data, coef_row and coef_last stay stable while coef_ready=0.
  - On coef_valid & coef_ready: row increments and the next beat is presented in the following cycle (one beat per cycle under full throughput).
  - Beat at row 7 carries coef_last=1. Its handshake returns the block to IDLE: coef_valid=0, coef_last=0, coef_row=0.
  - col_req_ready=0 throughout STREAM (macro off).
- Row counter is 3 bits and never wraps within a stream; column latch is not re-sampled mid-stream.
- aload_done deasserting after LOAD has no effect.
- Reset asserted mid-stream: immediate return to reset values; the partial stream is abandoned with no further beats.

Optional Feature:
- Macro: COEF_B2B_EN.
- Defined: col_req_ready is also high in STREAM during the last-beat handshake cycle (coef_valid & coef_ready & coef_last).
  - A request accepted in that cycle starts the new column's row-0 beat on the next cycle.
  - Zero-bubble back-to-back columns; state stays STREAM.
- Undefined: at least one idle cycle (coef_valid=0) separates consecutive columns.

Test Plan:
- Load: write buf[a] = {7'(2a), 7'(2a+1)} for a=0..15, then pulse aload_done -> buf_loaded=1 next cycle. Request col 2 -> beats rows 0..7 with data 16..23, coef_last only on row 7.
- Request before load: col_req_valid=1 held during LOAD -> col_req_ready=0, no coef_valid. After aload_done, request accepted and col 0 streams data 0..7.
- Backpressure: col 3 with coef_ready low for 3 cycles at row 4 -> coef_data=28, coef_row=4 held stable; stream resumes with 29, total 8 beats.
- Write after load: w_en=1, w_addr=0, w_data=14'h3FFF in IDLE -> col 0 still returns 0,1,...
- Reset mid-stream: rst low at row 5 of col 1 -> all outputs 0 at once, buf_loaded=0; a subsequent col request is not accepted until a new load plus aload_done.
- Back-to-back (COEF_B2B_EN): col 1 then col 2 requested on the last-beat cycle -> 16 consecutive valid cycles, data 8..15 then 16..23. Without the macro, one gap cycle between the two columns.

Source files
------------

// File: rtl/coef_col_streamer.sv
// Coefficient column streamer: buffers packed words from the loader, then
// serves one matrix column per request. Optional macro: COEF_B2B_EN.
module coef_col_streamer #(
  parameter int COEF_W = 7,
  parameter int WORD_W = 14,
  parameter int ROWS   = 8,
  parameter int COLS   = 4,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_en,
  input  logic [$clog2(DEPTH)-1:0] w_addr,
  input  logic [WORD_W-1:0]        w_data,
  input  logic                     aload_done,
  input  logic                     col_req_valid,
  output logic                     col_req_ready,
  input  logic [$clog2(COLS)-1:0]  col_sel,
  output logic                     coef_valid,
  input  logic                     coef_ready,
  output logic [COEF_W-1:0]        coef_data,
  output logic [$clog2(ROWS)-1:0]  coef_row,
  output logic                     coef_last,
  output logic                     buf_loaded
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  typedef enum logic [1:0] {
    S_LOAD,
    S_IDLE,
    S_STREAM
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] mem [DEPTH];
  logic [CW-1:0]     col_q;
  logic [RW-1:0]     row_nx;
  logic              hs;
  logic              last_hs;

  assign hs      = coef_valid & coef_ready;
  assign last_hs = hs & coef_last;
  assign row_nx  = coef_row + RW'(1);

  assign buf_loaded = (state != S_LOAD);

`ifdef COEF_B2B_EN
  assign col_req_ready = (state == S_IDLE) |
                         ((state == S_STREAM) & last_hs);
`else
  assign col_req_ready = (state == S_IDLE);
`endif

  // Even rows live in the upper half of a word, odd rows in the lower.
  function automatic logic [COEF_W-1:0] pick(
    input logic [CW-1:0] c,
    input logic [RW-1:0] r
  );
    logic [WORD_W-1:0] w;
    w = mem[AW'((ROWS/2)*int'(c) + int'(r >> 1))];
    return r[0] ? w[COEF_W-1:0] : w[WORD_W-1:COEF_W];
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_LOAD;
      col_q      <= '0;
      coef_valid <= 1'b0;
      coef_data  <= '0;
      coef_row   <= '0;
      coef_last  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state)
        S_LOAD: begin
          if (w_en) begin
            mem[w_addr] <= w_data;
          end
          if (aload_done) begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (col_req_valid) begin
            state      <= S_STREAM;
            col_q      <= col_sel;
            coef_valid <= 1'b1;
            coef_row   <= '0;
            coef_data  <= pick(col_sel, '0);
            coef_last  <= 1'b0;
          end
        end
        S_STREAM: begin
          if (hs) begin
            if (coef_last) begin
`ifdef COEF_B2B_EN
              if (col_req_valid) begin
                col_q      <= col_sel;
                coef_row   <= '0;
                coef_data  <= pick(col_sel, '0);
                coef_last  <= 1'b0;
              end else begin
                state      <= S_IDLE;
                coef_valid <= 1'b0;
                coef_data  <= '0;
                coef_row   <= '0;
                coef_last  <= 1'b0;
              end
`else
              state      <= S_IDLE;
              coef_valid <= 1'b0;
              coef_data  <= '0;
              coef_row   <= '0;
              coef_last  <= 1'b0;
`endif
            end else begin
              coef_row  <= row_nx;
              coef_data <= pick(col_q, row_nx);
              coef_last <= (row_nx == RW'(ROWS-1));
            end
          end
        end
        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coef_col_streamer.sv
// Randomized scoreboard bench for coef_col_streamer.
// Expected beats are queued on request acceptance; a monitor pops them.
module tb_coef_col_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_en = 1'b0;
  logic [3:0]  w_addr = '0;
  logic [13:0] w_data = '0;
  logic        aload_done = 1'b0;
  logic        col_req_valid = 1'b0;
  logic        col_req_ready;
  logic [1:0]  col_sel = '0;
  logic        coef_valid;
  logic        coef_ready;
  logic [6:0]  coef_data;
  logic [2:0]  coef_row;
  logic        coef_last;
  logic        buf_loaded;

  coef_col_streamer dut (
    .clk           (clk),
    .rst           (rst),
    .w_en          (w_en),
    .w_addr        (w_addr),
    .w_data        (w_data),
    .aload_done    (aload_done),
    .col_req_valid (col_req_valid),
    .col_req_ready (col_req_ready),
    .col_sel       (col_sel),
    .coef_valid    (coef_valid),
    .coef_ready    (coef_ready),
    .coef_data     (coef_data),
    .coef_row      (coef_row),
    .coef_last     (coef_last),
    .buf_loaded    (buf_loaded)
  );

  always #5 clk = ~clk;

  logic [13:0] model_mem [16];
  bit          model_loaded = 1'b0;
  logic [10:0] exp_q [$];

  int checks = 0;
  int errors = 0;
  int beats_done = 0;
  int bp_mode = 0;
  int stall = 0;
  int run_len = 0;
  int max_run = 0;
  bit prev_hold = 1'b0;
  bit prev_last_hs = 1'b0;
  logic [10:0] held = '0;

  function automatic logic [6:0] ref_coef(int c, int r);
    int w;
    w = int'(model_mem[c*4 + r/2]);
    if (r % 2 == 0) return 7'(w / 128);
    return 7'(w % 128);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples at negedge, where values are stable for the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      prev_hold = 1'b0;
      prev_last_hs = 1'b0;
      run_len = 0;
    end else begin
      if (coef_valid) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
`ifndef COEF_B2B_EN
      if (prev_last_hs) check("gap_after_last", 32'(coef_valid), 32'(0));
`endif
      if (prev_hold) begin
        check("hold_valid", 32'(coef_valid), 32'(1));
        check("hold_stable", 32'({coef_last, coef_row, coef_data}), 32'(held));
      end
      if (coef_valid && coef_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'({coef_last, coef_row, coef_data}), 32'h7FF_FFFF);
        end else begin
          check("beat", 32'({coef_last, coef_row, coef_data}), 32'(exp_q.pop_front()));
        end
        beats_done++;
      end
      prev_hold = coef_valid && !coef_ready;
      held = {coef_last, coef_row, coef_data};
      prev_last_hs = coef_valid && coef_ready && coef_last;
    end
  end

  // Consumer ready driver.
  initial begin
    coef_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        1: coef_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (beats_done % 8 == 4 && stall < 3) begin
            coef_ready = 1'b0;
            stall++;
          end else begin
            coef_ready = 1'b1;
          end
        end
        default: coef_ready = 1'b1;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(bit pattern);
    for (int a = 0; a < 16; a++) begin
      logic [13:0] d;
      d = pattern ? {7'(2*a), 7'(2*a+1)} : 14'($urandom);
      w_en = 1'b1;
      w_addr = 4'(a);
      w_data = d;
      aload_done = (a == 15);
      model_mem[a] = d;
      if (a == 0) check("loaded_before", 32'(buf_loaded), 32'(0));
      tick();
    end
    w_en = 1'b0;
    aload_done = 1'b0;
    model_loaded = 1'b1;
    check("buf_loaded", 32'(buf_loaded), 32'(1));
  endtask

  task automatic request(int c);
    bit ok;
    ok = 1'b0;
    col_sel = 2'(c);
    col_req_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = col_req_ready;
      tick();
    end
    col_req_valid = 1'b0;
    if (ok) begin
      for (int r = 0; r < 8; r++) begin
        exp_q.push_back({(r == 7), 3'(r), ref_coef(c, r)});
      end
    end else begin
      check("req_timeout", 32'(0), 32'(1));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() > 0; i++) tick();
    if (exp_q.size() > 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
    end
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    check("rst_valid", 32'(coef_valid), 32'(0));
    check("rst_data", 32'(coef_data), 32'(0));
    check("rst_row", 32'(coef_row), 32'(0));
    check("rst_last", 32'(coef_last), 32'(0));
    check("rst_req_ready", 32'(col_req_ready), 32'(0));
    check("rst_loaded", 32'(buf_loaded), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Request held during LOAD must be ignored.
    col_sel = 2'd0;
    col_req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("early_req_ready", 32'(col_req_ready), 32'(0));
      check("early_valid", 32'(coef_valid), 32'(0));
    end
    tick();
    load(1'b1);
    request(0);
    drain();

    request(2);
    drain();

    // Stall at row 4 of column 3.
    beats_done = 0;
    stall = 0;
    bp_mode = 2;
    request(3);
    drain();
    check("stall_cycles", 32'(stall), 32'(3));
    bp_mode = 0;

    // Writes after load are ignored.
    w_en = 1'b1;
    w_addr = 4'd0;
    w_data = 14'h3FFF;
    tick();
    w_en = 1'b0;
    request(0);
    drain();

    // Consecutive columns.
    max_run = 0;
    request(1);
    request(2);
    drain();
`ifdef COEF_B2B_EN
    check("b2b_run", 32'(max_run), 32'(16));
`else
    check("b2b_run", 32'(max_run), 32'(8));
`endif

    bp_mode = 1;
    for (int k = 0; k < 6; k++) begin
      request(int'($urandom_range(0, 3)));
      drain();
    end
    bp_mode = 0;

    // Reset in the middle of column 1.
    beats_done = 0;
    request(1);
    for (int i = 0; i < 50 && beats_done < 5; i++) tick();
    check("pre_reset_row", 32'(coef_row), 32'(5));
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    model_loaded = 1'b0;
    for (int a = 0; a < 16; a++) model_mem[a] = '0;
    check("mid_rst_valid", 32'(coef_valid), 32'(0));
    check("mid_rst_data", 32'(coef_data), 32'(0));
    check("mid_rst_row", 32'(coef_row), 32'(0));
    check("mid_rst_last", 32'(coef_last), 32'(0));
    check("mid_rst_loaded", 32'(buf_loaded), 32'(0));
    check("mid_rst_req_ready", 32'(col_req_ready), 32'(0));
    @(negedge clk);
    rst = 1'b1;
    tick();

    col_sel = 2'd1;
    col_req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_req_ready", 32'(col_req_ready), 32'(0));
      check("post_rst_valid", 32'(coef_valid), 32'(0));
    end
    tick();
    load(1'b0);
    request(1);
    drain();

    bp_mode = 1;
    for (int k = 0; k < 6; k++) begin
      request(int'($urandom_range(0, 3)));
      drain();
    end
    bp_mode = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
